simon_serial_host_if: RTL

Parallel-to-serial host adapter for the bit-serial Simon core. It latches a full plaintext and key from a parallel host interface. It then sequences the core through its reset, plaintext-load, key-load and run phases by driving the core's 1-bit data input and 2-bit phase code. Finally it deserialises the core's 1-bit cipher output back into a parallel ciphertext word with a done pulse. It sits directly upstream and downstream of the bit-serial top and is the only block that drives its data and phase inputs.

---
 rtl/simon_serial_host_if_if.sv | 37 +++
 rtl/simon_serial_host_if.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/simon_serial_host_if_if.sv
// rtl/simon_serial_host_if_if.sv - host and core-side signal bundle for the Simon serial adapter
//
// Purpose: groups the parallel host handshake and the bit-serial core link
// of simon_serial_host_if into one interface.
// Ports (signals):
//   host side : start, pt_in[BLOCK_W], key_in[KEY_W] -> adapter
//               busy, done, ct_out[BLOCK_W]          <- adapter
//   core side : core_data_in, core_data_rdy[2]       <- adapter
//               core_cipher_out                      -> adapter
// Modports: slave = the adapter's view, master = the host/core environment.

interface simon_serial_host_if_if #(
  parameter int BLOCK_W = 128,
  parameter int KEY_W   = 128
);

  logic               start;
  logic [BLOCK_W-1:0] pt_in;
  logic [KEY_W-1:0]   key_in;
  logic               busy;
  logic               done;
  logic [BLOCK_W-1:0] ct_out;
  logic               core_data_in;
  logic [1:0]         core_data_rdy;
  logic               core_cipher_out;

  modport slave (
    input  start, pt_in, key_in, core_cipher_out,
    output busy, done, ct_out, core_data_in, core_data_rdy
  );

  modport master (
    output start, pt_in, key_in, core_cipher_out,
    input  busy, done, ct_out, core_data_in, core_data_rdy
  );

endinterface

// File: rtl/simon_serial_host_if.sv
// rtl/simon_serial_host_if.sv - parallel-to-serial host adapter for the bit-serial Simon core
//
// Purpose: latches plaintext and key on start, streams them LSB first into the
// core (phase 1 then phase 2), holds the core in run for RUN_CYCLES, then
// deserialises BLOCK_W cipher bits into ct_out with a one-cycle done pulse.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : simon_serial_host_if_if.slave (host handshake + core serial link)

module simon_serial_host_if #(
  parameter int BLOCK_W    = 128,
  parameter int KEY_W      = 128,
  parameter int RUN_CYCLES = 4352
) (
  input  logic                      clk,
  input  logic                      rst_n,
  simon_serial_host_if_if.slave     bus
);

  localparam int MAX_BK = (BLOCK_W > KEY_W) ? BLOCK_W : KEY_W;
  localparam int MAX_N  = (MAX_BK > RUN_CYCLES) ? MAX_BK : RUN_CYCLES;
  localparam int CNT_W  = $clog2(MAX_N) + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD_PT, LOAD_KEY, RUN, CAPTURE, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] pt_sr_q, pt_sr_d;
  logic [KEY_W-1:0]   key_sr_q, key_sr_d;
  logic [BLOCK_W-1:0] ct_sr_q, ct_sr_d;
  logic [BLOCK_W-1:0] ct_out_q, ct_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         rdy_q, rdy_d;
  logic               din_q, din_d;

  // Next state and datapath. Outputs are computed from the *next* state and
  // shift-register contents so they can be registered while still lining up
  // with the cycle the FSM is in.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pt_sr_d  = pt_sr_q;
    key_sr_d = key_sr_q;
    ct_sr_d  = ct_sr_q;
    ct_out_d = ct_out_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pt_sr_d  = bus.pt_in;
          key_sr_d = bus.key_in;
          cnt_d    = CNT_W'(BLOCK_W - 1);
          state_d  = LOAD_PT;
        end
      end
      LOAD_PT: begin
        pt_sr_d = pt_sr_q >> 1;
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(KEY_W - 1);
          state_d = LOAD_KEY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOAD_KEY: begin
        key_sr_d = key_sr_q >> 1;
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(RUN_CYCLES - 1);
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(BLOCK_W - 1);
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CAPTURE: begin
        // First captured bit walks down to bit 0 after BLOCK_W shifts.
        ct_sr_d = {bus.core_cipher_out, ct_sr_q[BLOCK_W-1:1]};
        if (cnt_q == '0) begin
          ct_out_d = ct_sr_d;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    rdy_d  = 2'd0;
    din_d  = 1'b0;
    case (state_d)
      LOAD_PT: begin
        rdy_d = 2'd1;
        din_d = pt_sr_d[0];
      end
      LOAD_KEY: begin
        rdy_d = 2'd2;
        din_d = key_sr_d[0];
      end
      RUN, CAPTURE: begin
        rdy_d = 2'd3;
      end
      default: begin
        rdy_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pt_sr_q  <= '0;
      key_sr_q <= '0;
      ct_sr_q  <= '0;
      ct_out_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdy_q    <= 2'd0;
      din_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pt_sr_q  <= pt_sr_d;
      key_sr_q <= key_sr_d;
      ct_sr_q  <= ct_sr_d;
      ct_out_q <= ct_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdy_q    <= rdy_d;
      din_q    <= din_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.ct_out        = ct_out_q;
  assign bus.core_data_rdy = rdy_q;
  assign bus.core_data_in  = din_q;

endmodule
